// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives memory handshakes and datapath strobes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode, funct3      instruction fields from the decoder
//   imem_req/imem_ack   instruction fetch handshake
//   dmem_req/dmem_we    data access request and store qualifier
//   dmem_ack            data access complete
//   ir_we, pc_we        instruction-register load, PC advance
//   rf_we               register-file write enable
//   alu_src_imm         ALU operand B select (1 = immediate)
//   wb_sel              writeback source (00 ALU, 01 load data)
//   illegal, timeout    sticky halt causes
//   state               current state (debug)
//   retire_cnt          retired-instruction counter (wraps)
module mc_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        st_fetch  = 3'd0,
        st_decode = 3'd1,
        st_exec   = 3'd2,
        st_mem    = 3'd3,
        st_wb     = 3'd4,
        st_halt   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        cls_r     = 2'd0,
        cls_i     = 2'd1,
        cls_load  = 2'd2,
        cls_store = 2'd3
    } cls_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_WORD  = 3'b010;

    // Wide enough to hold TIMEOUT-1; at least one bit when timeout is disabled.
    localparam int WCW = $clog2(TIMEOUT + 2);
    localparam logic [WCW-1:0] TO_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]       state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [WCW-1:0]   wait_q;
    logic [CNT_W-1:0] retire_q;
    logic             illegal_q, timeout_q;

    logic wait_inc;
    logic retire_inc;
    logic set_ill;
    logic set_to;
    logic to_hit;

    // This is the TIMEOUT-th consecutive cycle of an unacknowledged request.
    assign to_hit = (TIMEOUT > 0) && (wait_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = 2'b00;
        wait_inc    = 1'b0;
        retire_inc  = 1'b0;
        set_ill     = 1'b0;
        set_to      = 1'b0;

        unique case (state_q)
            st_fetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = st_decode;
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_d = st_halt;
                end else begin
                    wait_inc = 1'b1;
                end
            end

            st_decode: begin
                state_d = st_exec;
                unique case (opcode)
                    OP_R: cls_d = cls_r;
                    OP_I: cls_d = cls_i;
                    OP_LOAD: begin
                        cls_d = cls_load;
                        if (funct3 != F3_WORD) begin
                            set_ill = 1'b1;
                            state_d = st_halt;
                        end
                    end
                    OP_STORE: begin
                        cls_d = cls_store;
                        if (funct3 != F3_WORD) begin
                            set_ill = 1'b1;
                            state_d = st_halt;
                        end
                    end
                    default: begin
                        set_ill = 1'b1;
                        state_d = st_halt;
                    end
                endcase
            end

            st_exec: begin
                if (cls_q == cls_load || cls_q == cls_store) begin
                    state_d = st_mem;
                end else begin
                    state_d = st_wb;
                end
            end

            st_mem: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == cls_store);
                if (dmem_ack) begin
                    if (cls_q == cls_store) begin
                        pc_we      = 1'b1;
                        retire_inc = 1'b1;
                        state_d    = st_fetch;
                    end else begin
                        state_d = st_wb;
                    end
                end else if (to_hit) begin
                    set_to  = 1'b1;
                    state_d = st_halt;
                end else begin
                    wait_inc = 1'b1;
                end
            end

            st_wb: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                retire_inc = 1'b1;
                state_d    = st_fetch;
            end

            st_halt: begin
                state_d = st_halt;
            end

            default: begin
                state_d = st_halt;
            end
        endcase

        // Operand B is the immediate for everything but R-type once classified.
        if ((state_q == st_exec || state_q == st_mem || state_q == st_wb) &&
            cls_q != cls_r) begin
            alu_src_imm = 1'b1;
        end

        if (state_q == st_wb && cls_q == cls_load) begin
            wb_sel = 2'b01;
        end

        // Requests drop in the very cycle reset is asserted.
        if (!rst_n) begin
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            rf_we       = 1'b0;
            alu_src_imm = 1'b0;
            wb_sel      = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= st_fetch;
            cls_q     <= cls_r;
            wait_q    <= '0;
            retire_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            // Any state change restarts the wait count, so entry to FETCH/MEM sees 0.
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (wait_inc) begin
                wait_q <= wait_q + WCW'(1);
            end
            if (retire_inc) begin
                retire_q <= retire_q + CNT_W'(1);
            end
            if (set_ill) begin
                illegal_q <= 1'b1;
            end
            if (set_to) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign state      = state_q;
    assign retire_cnt = retire_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// Table-driven cycle vectors through a scoreboard queue, plus corner-case sequences.
module tb_mc_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_req, imem_ack;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       ir_we, pc_we, rf_we, alu_src_imm;
    logic [1:0] wb_sel;
    logic       illegal, timeout;
    logic [2:0] state;
    logic [3:0] retire_cnt;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
        .illegal(illegal), .timeout(timeout),
        .state(state), .retire_cnt(retire_cnt)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        ia;
        logic        da;
        logic [15:0] exp;
    } vec_t;

    vec_t        v[18];
    logic [15:0] sb[$];
    int          total = 0;
    int          bad = 0;

    // {retire_cnt, state, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, imm, wb_sel}
    function automatic logic [15:0] ex(logic [3:0] rc, logic [2:0] st,
                                       logic [6:0] s, logic [1:0] wb);
        return {rc, st, s, wb};
    endfunction

    task automatic setv(int i, logic [6:0] op, logic [2:0] f3,
                        logic ia, logic da, logic [15:0] e);
        v[i].op = op; v[i].f3 = f3; v[i].ia = ia; v[i].da = da; v[i].exp = e;
    endtask

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic drv(logic r, logic [6:0] op, logic [2:0] f3, logic ia, logic da);
        rst_n = r; opcode = op; funct3 = f3; imem_ack = ia; dmem_ack = da;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH just after an edge, with rst_n already high.
    task automatic do_reset();
        drv(1'b0, OP_R, 3'd0, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we,
                                rf_we, alu_src_imm, wb_sel}), 32'd0);
        chk("rst_cnt", 32'(retire_cnt), 32'd0);
        chk("rst_flags", 32'({illegal, timeout}), 32'd0);
        step();
        drv(1'b1, OP_R, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] e;

        // R-type, zero wait; acks outside FETCH/MEM must be ignored
        setv(0,  OP_R, 3'd0, 1, 0, ex(0, 0, 7'b1001000, 2'b00));
        setv(1,  OP_R, 3'd0, 1, 1, ex(0, 1, 7'b0000000, 2'b00));
        setv(2,  OP_R, 3'd0, 1, 1, ex(0, 2, 7'b0000000, 2'b00));
        setv(3,  OP_R, 3'd0, 0, 0, ex(0, 4, 7'b0000110, 2'b00));
        // LW: three fetch wait cycles, one data wait cycle -> 9 cycles
        setv(4,  OP_LW, 3'd2, 0, 0, ex(1, 0, 7'b1000000, 2'b00));
        setv(5,  OP_LW, 3'd2, 0, 0, ex(1, 0, 7'b1000000, 2'b00));
        setv(6,  OP_LW, 3'd2, 0, 0, ex(1, 0, 7'b1000000, 2'b00));
        setv(7,  OP_LW, 3'd2, 1, 0, ex(1, 0, 7'b1001000, 2'b00));
        setv(8,  OP_LW, 3'd2, 0, 0, ex(1, 1, 7'b0000000, 2'b00));
        setv(9,  OP_LW, 3'd2, 0, 0, ex(1, 2, 7'b0000001, 2'b00));
        setv(10, OP_LW, 3'd2, 0, 0, ex(1, 3, 7'b0100001, 2'b00));
        setv(11, OP_LW, 3'd2, 0, 1, ex(1, 3, 7'b0100001, 2'b00));
        setv(12, OP_LW, 3'd2, 0, 0, ex(1, 4, 7'b0000111, 2'b01));
        // SW zero wait
        setv(13, OP_SW, 3'd2, 1, 0, ex(2, 0, 7'b1001000, 2'b00));
        setv(14, OP_SW, 3'd2, 0, 0, ex(2, 1, 7'b0000000, 2'b00));
        setv(15, OP_SW, 3'd2, 0, 0, ex(2, 2, 7'b0000001, 2'b00));
        setv(16, OP_SW, 3'd2, 0, 1, ex(2, 3, 7'b0110101, 2'b00));
        setv(17, OP_R,  3'd0, 0, 0, ex(3, 0, 7'b1000000, 2'b00));

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drv(1'b1, v[i].op, v[i].f3, v[i].ia, v[i].da);
            sb.push_back(v[i].exp);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("vec%0d", i),
                    32'({retire_cnt, state, imem_req, dmem_req, dmem_we, ir_we,
                         pc_we, rf_we, alu_src_imm, wb_sel}), 32'(e));
            end
            step();
        end

        // Illegal opcode: halts after DECODE, no further fetch
        do_reset();
        drv(1'b1, OP_JL, 3'd0, 1'b1, 1'b0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ill_halt%0d", k),
                32'({state, imem_req, illegal, timeout}), 32'({3'd5, 1'b0, 1'b1, 1'b0}));
            step();
        end

        // LOAD with funct3=000 is illegal
        do_reset();
        drv(1'b1, OP_LW, 3'd0, 1'b1, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("ld_f3_ill", 32'({state, illegal, retire_cnt}), 32'({3'd5, 1'b1, 4'd0}));
        step();

        // Fetch timeout: 15 unacked request cycles then HALT
        do_reset();
        drv(1'b1, OP_R, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 32'({state, imem_req}), 32'({3'd0, 1'b1}));
            step();
        end
        @(negedge clk);
        chk("to_halt", 32'({state, imem_req, timeout, illegal}),
            32'({3'd5, 1'b0, 1'b1, 1'b0}));
        step();

        // Ack on the 15th cycle wins over timeout
        do_reset();
        for (int k = 1; k < 15; k++) step();
        drv(1'b1, OP_R, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("to_ack_irwe", 32'(ir_we), 32'd1);
        step();
        drv(1'b1, OP_R, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_ack_decode", 32'({state, timeout}), 32'({3'd1, 1'b0}));
        step();

        // 17 retirements wrap a 4-bit counter to 1
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drv(1'b1, OP_R, 3'd0, 1'b1, 1'b0);
            step();
            drv(1'b1, OP_R, 3'd0, 1'b0, 1'b0);
            step();
            step();
            step();
        end
        @(negedge clk);
        chk("wrap_cnt", 32'({state, retire_cnt}), 32'({3'd0, 4'd1}));

        // Reset during a store MEM cycle with ack: nothing issued, nothing retired
        drv(1'b1, OP_SW, 3'd2, 1'b1, 1'b0);
        step();
        drv(1'b1, OP_SW, 3'd2, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("mid_in_mem", 32'({state, dmem_req}), 32'({3'd3, 1'b1}));
        drv(1'b0, OP_SW, 3'd2, 1'b0, 1'b1);
        #1;
        chk("mid_rst_drop", 32'({dmem_req, dmem_we, pc_we}), 32'd0);
        step();
        @(negedge clk);
        chk("mid_rst_after", 32'({state, retire_cnt}), 32'({3'd0, 4'd0}));
        step();

        // Data timeout on a store
        do_reset();
        drv(1'b1, OP_SW, 3'd2, 1'b1, 1'b0);
        step();
        drv(1'b1, OP_SW, 3'd2, 1'b0, 1'b0);
        step();
        step();
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("dto_wait%0d", k), 32'({state, dmem_req, dmem_we}),
                32'({3'd3, 1'b1, 1'b1}));
            step();
        end
        @(negedge clk);
        chk("dto_halt", 32'({state, dmem_req, timeout, retire_cnt}),
            32'({3'd5, 1'b0, 1'b1, 4'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
